// File: rtl/srec_stream_parser_if.sv
// Character stream in, byte-write bus out, for the S-record parser.
interface srec_stream_parser_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [7:0]            char_data;
  logic                  char_ready;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [7:0]            write_byte;
  logic                  write_enable;

  modport master (output char_data, char_ready,
                  input  write_address, write_byte, write_enable);
  modport slave  (input  char_data, char_ready,
                  output write_address, write_byte, write_enable);
endinterface

// File: rtl/srec_stream_parser.sv
// Streaming Motorola S-record parser (S0/1/2/3/5/7/8/9) for the UART boot path.
// Emits byte writes, captures the entry point and flags syntax/checksum errors.
module srec_stream_parser #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter bit          ALLOW_LOWERCASE = 1'b1,
  parameter int unsigned LOC_WIDTH       = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  srec_stream_parser_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] entry_address,
  output logic                  entry_valid,
  output logic                  in_progress,
  output logic                  done,
  output logic [15:0]           record_count,
  output logic                  format_error,
  output logic                  checksum_error,
  output logic [LOC_WIDTH-1:0]  error_location
);

  localparam int unsigned FIELD_W = 32;
  localparam logic [7:0]  CHAR_S  = 8'h53;
  localparam logic [7:0]  CHAR_CR = 8'h0D;
  localparam logic [7:0]  CHAR_LF = 8'h0A;

  typedef enum logic [3:0] {
    IDLE, TYPE, COUNT_H, COUNT_L, ADDR, DATA_H, DATA_L, CSUM_H, CSUM_L, EOL
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            type_q, type_d;
  logic [3:0]            addr_nib_q, addr_nib_d;
  logic [3:0]            nib_cnt_q, nib_cnt_d;
  logic [3:0]            hi_q, hi_d;
  logic [FIELD_W-1:0]    addr_q, addr_d;
  logic [7:0]            left_q, left_d;
  logic [7:0]            idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_byte_q, wr_byte_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] entry_address_d;
  logic                  entry_valid_d, in_progress_d, done_d;
  logic [15:0]           record_count_d;
  logic                  format_error_d, checksum_error_d;
  logic [LOC_WIDTH-1:0]  error_location_d;

  logic       hex_ok, go, is_write, is_term, is_eol;
  logic [3:0] nib;
  logic [7:0] byte_val, addr_bytes;

  // Hex digit decode of the current character
  always_comb begin
    hex_ok = 1'b0;
    nib    = 4'd0;
    if (bus.char_data >= 8'h30 && bus.char_data <= 8'h39) begin
      hex_ok = 1'b1;
      nib    = bus.char_data[3:0];
    end else if (bus.char_data >= 8'h41 && bus.char_data <= 8'h46) begin
      hex_ok = 1'b1;
      nib    = bus.char_data[3:0] + 4'd9;
    end else if (ALLOW_LOWERCASE && bus.char_data >= 8'h61 && bus.char_data <= 8'h66) begin
      hex_ok = 1'b1;
      nib    = bus.char_data[3:0] + 4'd9;
    end
  end

  assign byte_val   = {hi_q, nib};
  assign addr_bytes = 8'(addr_nib_q[3:1]);
  assign is_write   = (type_q == 4'd1) || (type_q == 4'd2) || (type_q == 4'd3);
  assign is_term    = (type_q == 4'd7) || (type_q == 4'd8) || (type_q == 4'd9);
  assign is_eol     = (bus.char_data == CHAR_CR) || (bus.char_data == CHAR_LF);
  // Once any error is latched the parser is frozen
  assign go         = bus.char_ready && !format_error && !checksum_error;

  // Next-state and datapath
  always_comb begin
    state_d          = state_q;
    type_d           = type_q;
    addr_nib_d       = addr_nib_q;
    nib_cnt_d        = nib_cnt_q;
    hi_d             = hi_q;
    addr_d           = addr_q;
    left_d           = left_q;
    idx_d            = idx_q;
    sum_d            = sum_q;
    wr_addr_d        = wr_addr_q;
    wr_byte_d        = wr_byte_q;
    wr_en_d          = 1'b0;
    entry_address_d  = entry_address;
    entry_valid_d    = entry_valid;
    in_progress_d    = in_progress;
    done_d           = done;
    record_count_d   = record_count;
    format_error_d   = format_error;
    checksum_error_d = checksum_error;
    error_location_d = error_location;

    if (clear) begin
      state_d          = IDLE;
      type_d           = 4'd0;
      addr_nib_d       = 4'd0;
      nib_cnt_d        = 4'd0;
      hi_d             = 4'd0;
      addr_d           = '0;
      left_d           = 8'd0;
      idx_d            = 8'd0;
      sum_d            = 8'd0;
      wr_addr_d        = '0;
      wr_byte_d        = 8'd0;
      entry_address_d  = '0;
      entry_valid_d    = 1'b0;
      in_progress_d    = 1'b0;
      done_d           = 1'b0;
      record_count_d   = 16'd0;
      format_error_d   = 1'b0;
      checksum_error_d = 1'b0;
      error_location_d = '0;
    end else if (go) begin
      if (error_location != '1) error_location_d = error_location + LOC_WIDTH'(1);
      unique case (state_q)
        IDLE: begin
          if (bus.char_data == CHAR_S) state_d = TYPE;
          else if (!is_eol)            format_error_d = 1'b1;
        end
        TYPE: begin
          type_d  = bus.char_data[3:0];
          addr_d  = '0;
          sum_d   = 8'd0;
          idx_d   = 8'd0;
          state_d = COUNT_H;
          case (bus.char_data)
            8'h30, 8'h35, 8'h39: addr_nib_d = 4'd4;
            8'h31: begin addr_nib_d = 4'd4; in_progress_d = 1'b1; end
            8'h32: begin addr_nib_d = 4'd6; in_progress_d = 1'b1; end
            8'h33: begin addr_nib_d = 4'd8; in_progress_d = 1'b1; end
            8'h38: addr_nib_d = 4'd6;
            8'h37: addr_nib_d = 4'd8;
            default: begin format_error_d = 1'b1; state_d = TYPE; end
          endcase
        end
        COUNT_H, DATA_H, CSUM_H: begin
          if (!hex_ok) format_error_d = 1'b1;
          else begin
            hi_d = nib;
            state_d = (state_q == COUNT_H) ? COUNT_L :
                      (state_q == DATA_H)  ? DATA_L  : CSUM_L;
          end
        end
        COUNT_L: begin
          if (!hex_ok || byte_val < addr_bytes + 8'd1) format_error_d = 1'b1;
          else begin
            sum_d     = byte_val;
            left_d    = byte_val - addr_bytes - 8'd1;
            nib_cnt_d = addr_nib_q;
            state_d   = ADDR;
          end
        end
        ADDR: begin
          if (!hex_ok) format_error_d = 1'b1;
          else begin
            addr_d    = {addr_q[FIELD_W-5:0], nib};
            nib_cnt_d = nib_cnt_q - 4'd1;
            // Odd remaining count marks the low nibble of an address byte
            if (nib_cnt_q[0]) sum_d = sum_q + {addr_q[3:0], nib};
            if (nib_cnt_q == 4'd1) state_d = (left_q == 8'd0) ? CSUM_H : DATA_H;
          end
        end
        DATA_L: begin
          if (!hex_ok) format_error_d = 1'b1;
          else begin
            sum_d  = sum_q + byte_val;
            idx_d  = idx_q + 8'd1;
            left_d = left_q - 8'd1;
            if (is_write) begin
              wr_en_d   = 1'b1;
              wr_byte_d = byte_val;
              wr_addr_d = ADDR_WIDTH'(addr_q) + ADDR_WIDTH'(idx_q);
            end
            state_d = (left_q == 8'd1) ? CSUM_H : DATA_H;
          end
        end
        CSUM_L: begin
          if (!hex_ok) format_error_d = 1'b1;
          else if (~sum_q != byte_val) checksum_error_d = 1'b1;
          else begin
            if (record_count != 16'hFFFF) record_count_d = record_count + 16'd1;
            if (is_term) begin
              entry_address_d = ADDR_WIDTH'(addr_q);
              entry_valid_d   = 1'b1;
              done_d          = 1'b1;
              in_progress_d   = 1'b0;
            end
            state_d = EOL;
          end
        end
        EOL: begin
          if (is_eol) state_d = IDLE;
          else        format_error_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      type_q         <= 4'd0;
      addr_nib_q     <= 4'd0;
      nib_cnt_q      <= 4'd0;
      hi_q           <= 4'd0;
      addr_q         <= '0;
      left_q         <= 8'd0;
      idx_q          <= 8'd0;
      sum_q          <= 8'd0;
      wr_addr_q      <= '0;
      wr_byte_q      <= 8'd0;
      wr_en_q        <= 1'b0;
      entry_address  <= '0;
      entry_valid    <= 1'b0;
      in_progress    <= 1'b0;
      done           <= 1'b0;
      record_count   <= 16'd0;
      format_error   <= 1'b0;
      checksum_error <= 1'b0;
      error_location <= '0;
    end else begin
      state_q        <= state_d;
      type_q         <= type_d;
      addr_nib_q     <= addr_nib_d;
      nib_cnt_q      <= nib_cnt_d;
      hi_q           <= hi_d;
      addr_q         <= addr_d;
      left_q         <= left_d;
      idx_q          <= idx_d;
      sum_q          <= sum_d;
      wr_addr_q      <= wr_addr_d;
      wr_byte_q      <= wr_byte_d;
      wr_en_q        <= wr_en_d;
      entry_address  <= entry_address_d;
      entry_valid    <= entry_valid_d;
      in_progress    <= in_progress_d;
      done           <= done_d;
      record_count   <= record_count_d;
      format_error   <= format_error_d;
      checksum_error <= checksum_error_d;
      error_location <= error_location_d;
    end
  end

  assign bus.write_address = wr_addr_q;
  assign bus.write_byte    = wr_byte_q;
  assign bus.write_enable  = wr_en_q;

endmodule

// File: tb/tb_srec_stream_parser.sv
// Directed bench: default, 16-bit-address and uppercase-only parsers share one stream.
module tb_srec_stream_parser;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] ch = 8'd0;
  logic       rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  srec_stream_parser_if #(.ADDR_WIDTH(32)) bus0 ();
  srec_stream_parser_if #(.ADDR_WIDTH(16)) bus1 ();
  srec_stream_parser_if #(.ADDR_WIDTH(32)) bus2 ();

  assign bus0.char_data = ch;  assign bus0.char_ready = rdy;
  assign bus1.char_data = ch;  assign bus1.char_ready = rdy;
  assign bus2.char_data = ch;  assign bus2.char_ready = rdy;

  logic [31:0] ea0, ea2;
  logic [15:0] ea1;
  logic        ev0, ip0, dn0, fe0, ce0;
  logic        ev1, ip1, dn1, fe1, ce1;
  logic        ev2, ip2, dn2, fe2, ce2;
  logic [15:0] rc0, rc1, rc2, el0, el1, el2;

  srec_stream_parser dut (
    .clock(clock), .reset_n(reset_n), .clear(clr), .bus(bus0),
    .entry_address(ea0), .entry_valid(ev0), .in_progress(ip0), .done(dn0),
    .record_count(rc0), .format_error(fe0), .checksum_error(ce0), .error_location(el0));

  srec_stream_parser #(.ADDR_WIDTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .clear(clr), .bus(bus1),
    .entry_address(ea1), .entry_valid(ev1), .in_progress(ip1), .done(dn1),
    .record_count(rc1), .format_error(fe1), .checksum_error(ce1), .error_location(el1));

  srec_stream_parser #(.ALLOW_LOWERCASE(1'b0)) dut_uc (
    .clock(clock), .reset_n(reset_n), .clear(clr), .bus(bus2),
    .entry_address(ea2), .entry_valid(ev2), .in_progress(ip2), .done(dn2),
    .record_count(rc2), .format_error(fe2), .checksum_error(ce2), .error_location(el2));

  // Write logs, sampled mid-cycle
  logic [39:0] wq0[$];
  logic [23:0] wq1[$];
  int          wr2 = 0;

  always @(negedge clock) begin
    if (bus0.write_enable === 1'b1) wq0.push_back({bus0.write_address, bus0.write_byte});
    if (bus1.write_enable === 1'b1) wq1.push_back({bus1.write_address, bus1.write_byte});
    if (bus2.write_enable === 1'b1) wr2++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      ch  = s[i];
      rdy = 1'b1;
      @(negedge clock);
    end
    rdy = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    @(negedge clock);
    wq0.delete();
    wq1.delete();
    wr2 = 0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_wen", 64'(bus0.write_enable), 64'd0);
    chk("rst_rc", 64'(rc0), 64'd0);
    chk("rst_done", 64'(dn0), 64'd0);
    chk("rst_err", 64'({fe0, ce0}), 64'd0);
    chk("rst_loc", 64'(el0), 64'd0);
    chk("rst_entry", 64'({ev0, ea0}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic S1 record with CRLF
    send("S1051000AABB85\r\n");
    chk("s1_nwr", 64'(wq0.size()), 64'd2);
    chk("s1_wr0", 64'(wq0[0]), 64'h00_0000_1000_AA);
    chk("s1_wr1", 64'(wq0[1]), 64'h00_0000_1001_BB);
    chk("s1_rc", 64'(rc0), 64'd1);
    chk("s1_err", 64'({fe0, ce0}), 64'd0);
    chk("s1_inprog", 64'(ip0), 64'd1);
    chk("s1_done", 64'(dn0), 64'd0);
    chk("s1_uc_rc", 64'(rc2), 64'd1);

    do_clear();
    chk("clr_rc", 64'(rc0), 64'd0);
    chk("clr_inprog", 64'(ip0), 64'd0);
    chk("clr_loc", 64'(el0), 64'd0);

    // S3 data then S9 and S7 termination
    send("S30912345678DEADBEEFAA\n");
    chk("s3_nwr", 64'(wq0.size()), 64'd4);
    chk("s3_wr0", 64'(wq0[0]), 64'h00_1234_5678_DE);
    chk("s3_wr1", 64'(wq0[1]), 64'h00_1234_5679_AD);
    chk("s3_wr2", 64'(wq0[2]), 64'h00_1234_567A_BE);
    chk("s3_wr3", 64'(wq0[3]), 64'h00_1234_567B_EF);
    chk("s3_a16_n", 64'(wq1.size()), 64'd4);
    chk("s3_a16_0", 64'(wq1[0]), 64'h5678DE);
    chk("s3_a16_3", 64'(wq1[3]), 64'h567BEF);
    chk("s3_inprog", 64'(ip0), 64'd1);
    send("S9030000FC\r\n");
    chk("s9_entry", 64'(ea0), 64'd0);
    chk("s9_ev", 64'(ev0), 64'd1);
    chk("s9_done", 64'(dn0), 64'd1);
    chk("s9_inprog", 64'(ip0), 64'd0);
    chk("s9_rc", 64'(rc0), 64'd2);
    send("S70500001234B4\n");
    chk("s7_entry", 64'(ea0), 64'h1234);
    chk("s7_rc", 64'(rc0), 64'd3);
    chk("s7_done", 64'(dn0), 64'd1);
    chk("s7_nwr", 64'(wq0.size()), 64'd4);

    // Checksum error freezes the parser
    do_clear();
    send("S30912345678DEADBEEFAB\n");
    chk("ce_nwr", 64'(wq0.size()), 64'd4);
    chk("ce_flag", 64'({fe0, ce0}), 64'b01);
    chk("ce_loc", 64'(el0), 64'd22);
    send("S1051000AABB85\r\n");
    chk("ce_frz_nwr", 64'(wq0.size()), 64'd4);
    chk("ce_frz_loc", 64'(el0), 64'd22);
    chk("ce_frz_rc", 64'(rc0), 64'd0);
    do_clear();
    chk("ce_clr", 64'({fe0, ce0, el0}), 64'd0);

    // Illegal type digit
    send("S4\n");
    chk("t4_fe", 64'(fe0), 64'd1);
    chk("t4_loc", 64'(el0), 64'd2);
    chk("t4_nwr", 64'(wq0.size()), 64'd0);
    do_clear();

    // Count smaller than address + checksum
    send("S1021000\n");
    chk("cnt_fe", 64'(fe0), 64'd1);
    chk("cnt_loc", 64'(el0), 64'd4);
    do_clear();

    // Leading blank lines, then S1 and S2 records
    send("\r\n\r\nS1051000AABB85\r\n");
    chk("bl_err", 64'({fe0, ce0}), 64'd0);
    chk("bl_loc", 64'(el0), 64'd20);
    send("S2050100FF12E8\n");
    chk("s2_rc", 64'(rc0), 64'd2);
    chk("s2_nwr", 64'(wq0.size()), 64'd3);
    chk("s2_wr", 64'(wq0[2]), 64'h00_0001_00FF_12);
    chk("s2_a16", 64'(wq1[2]), 64'h00FF12);
    do_clear();

    // Lowercase hex: accepted by default, rejected when disabled
    send("S1051000aabb85\r\n");
    chk("lc_nwr", 64'(wq0.size()), 64'd2);
    chk("lc_wr0", 64'(wq0[0]), 64'h00_0000_1000_AA);
    chk("lc_wr1", 64'(wq0[1]), 64'h00_0000_1001_BB);
    chk("lc_rc", 64'(rc0), 64'd1);
    chk("uc_fe", 64'(fe2), 64'd1);
    chk("uc_loc", 64'(el2), 64'd9);
    chk("uc_nwr", 64'(wr2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
